fir_tap_sequencer: RTL
======================

Name: fir_tap_sequencer

Overview:
- Initiator side of the FIR ALU operand interface: the block that drives `a`/`b`/`select` into the ALU and consumes its 32-bit result.
- Accepts input samples over a valid/ready handshake and keeps them in a circular delay line.
- For each accepted sample, issues one multiply per tap to the ALU and accumulates the returned products.
- Presents the filtered output word over a valid/ready handshake. Sits between the sample source and the FIR output path.

Parameters:
- TAPS, 8, number of filter taps (power of two, >=2)
- ALU_LATENCY, 2, cycles from operands/select presented to the matching alu_result being valid (>=1)
- DW, 16, sample/coefficient width (signed)
- RW, 32, ALU result and accumulator width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- coef_we  in  1  coefficient write strobe
- coef_addr  in  log2(TAPS)  coefficient index k
- coef_data  in  DW  signed coefficient h[k]
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample
- in_sample  in  DW  signed sample x[n]
- alu_a  out  DW  ALU operand a (sample)
- alu_b  out  DW  ALU operand b (coefficient)
- alu_select  out  2  ALU op: 2'b01 multiply, 2'b00 otherwise
- alu_result  in  RW  ALU result, signed product a*b
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  RW  y[n] = sum over k of h[k]*x[n-k], modulo 2^RW
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, takes priority over all other activity, including mid-operation):
  - state=IDLE, wr_ptr=0, accumulator=0, pending-result tags cleared.
  - Delay line and coefficient bank cleared to 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, alu_a=0, alu_b=0, alu_select=2'b00, busy=0.
- FSM states: IDLE, ISSUE, DRAIN, OUT.
- IDLE:
  - in_ready=1.
  - When coef_we is high, coef[coef_addr] <= coef_data.
  - When in_valid & in_ready: delay[wr_ptr] <= in_sample, wr_ptr <= wr_ptr+1 (mod TAPS), accumulator <= 0, tap counter k <= 0, go to ISSUE.
  - A coef_we in the same cycle as a sample accept is applied, and is visible to that sample's computation.
- ISSUE (exactly TAPS cycles, k = 0..TAPS-1):
  - alu_a = delay[(newest_ptr - k) mod TAPS], where newest_ptr is the slot just written.
  - alu_b = coef[k], alu_select = 2'b01.
  - A valid tag enters a shift register ALU_LATENCY deep.
  - After k=TAPS-1, go to DRAIN.
- Outside ISSUE: alu_a=0, alu_b=0, alu_select=2'b00, and no tag is inserted.
- Accumulate: on every cycle where the tag at the shift-register output is 1, accumulator <= accumulator + alu_result (two's complement, wraps modulo 2^RW, no saturation).
- DRAIN: wait until all tags have retired (last product accumulated), then out_data <= accumulator and go to OUT.
- OUT:
  - out_valid=1; out_data is held stable until out_ready.
  - When out_valid & out_ready: out_valid <= 0, go to IDLE.
- Latency: sample accepted at cycle 0 → ISSUE in cycles 1..TAPS → out_valid rises at cycle TAPS+ALU_LATENCY+1 (cycle 11 at defaults) with out_ready held high.
- Throughput: one sample per TAPS+ALU_LATENCY+2 cycles.
- in_ready=0 in ISSUE/DRAIN/OUT; in_valid is ignored there.
- coef_we outside IDLE is ignored; the coefficient bank is unchanged.
- Delay-line wrap: after TAPS accepts, wr_ptr returns to 0 and the oldest sample is overwritten. Until TAPS samples have arrived after reset, missing history reads as 0.

Test Plan:
- Impulse: load coef[k]=k+1 (k=0..7), push samples 1,0,0,0,0,0,0,0,0 → out_data = 1,2,3,4,5,6,7,8,0. First out_valid at cycle 11 after accept.
- Wrap: all coef=0x7FFF, push eight samples 0x7FFF → 8th out_data = 0xFFF80008 (8*0x3FFF0001 mod 2^32).
- Signed: coef[0]=-1 (0xFFFF), others 0, push -32768 (0x8000) → out_data = 0x00008000.
- Backpressure: hold out_ready=0 for 5 cycles in OUT, with in_valid=1 and a changing in_sample → out_valid and out_data stable, in_ready=0, no sample captured. After out_ready=1: one transfer, then IDLE.
- Coef write while busy: coef_we with coef[0]=5 during ISSUE → ignored. Same write repeated in IDLE → next impulse output's first term = 5.
- Reset mid-ISSUE (k=3): assert rst one cycle → next cycle state IDLE, out_valid=0, alu_select=2'b00, in_ready=1. Reload coef[0]=2 (bank cleared by reset), push impulse 1 → out_data=2, with no stale products accumulated.

Source files
------------

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: streams samples through a circular delay line and
// drives one multiply per tap into an external pipelined ALU.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   coef_we/coef_addr/coef_data  coefficient bank write (IDLE only)
//   in_valid/in_ready/in_sample  sample input handshake
//   alu_a/alu_b/alu_select       ALU operands and op (01 = multiply)
//   alu_result                   ALU product, ALU_LATENCY cycles later
//   out_valid/out_ready/out_data filtered output handshake
//   busy                         high whenever not IDLE
module fir_tap_sequencer #(
  parameter int TAPS        = 8,
  parameter int ALU_LATENCY = 2,
  parameter int DW          = 16,
  parameter int RW          = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [DW-1:0]           coef_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           in_sample,
  output logic [DW-1:0]           alu_a,
  output logic [DW-1:0]           alu_b,
  output logic [1:0]              alu_select,
  input  logic [RW-1:0]           alu_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RW-1:0]           out_data,
  output logic                    busy
);

  localparam int AW = $clog2(TAPS);

  // All tag bits except the one at the shift-register output.
  localparam logic [ALU_LATENCY-1:0] REST =
    {ALU_LATENCY{1'b1}} >> 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DW-1:0]          coef  [TAPS];
  logic [DW-1:0]          delay [TAPS];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          k;
  logic [AW-1:0]          rd_idx;
  logic [ALU_LATENCY-1:0] tags;
  logic [RW-1:0]          acc;
  logic [RW-1:0]          acc_sum;
  logic                   tag_out;
  logic                   issue;
  logic                   last_tap;
  logic                   drained;

  assign issue    = (state == ISSUE);
  assign tag_out  = tags[ALU_LATENCY-1];
  assign last_tap = (k == AW'(TAPS - 1));
  assign drained  = ((tags & REST) == '0);
  assign acc_sum  = acc + (tag_out ? alu_result : '0);

  // wr_ptr already advanced past the newest sample, so newest is wr_ptr-1.
  assign rd_idx = wr_ptr - AW'(1) - k;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    alu_a      = '0;
    alu_b      = '0;
    alu_select = 2'b00;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        alu_a      = delay[rd_idx];
        alu_b      = coef[k];
        alu_select = 2'b01;
        if (last_tap) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          state_nx = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      k        <= '0;
      tags     <= '0;
      acc      <= '0;
      out_data <= '0;
      for (int i = 0; i < TAPS; i++) begin
        coef[i]  <= '0;
        delay[i] <= '0;
      end
    end else begin
      tags <= (tags << 1) | ALU_LATENCY'(issue);
      if (tag_out) begin
        acc <= acc_sum;
      end
      if (state == IDLE) begin
        if (coef_we) begin
          coef[coef_addr] <= coef_data;
        end
        if (in_valid) begin
          delay[wr_ptr] <= in_sample;
          wr_ptr        <= wr_ptr + AW'(1);
          acc           <= '0;
          k             <= '0;
        end
      end
      if (issue) begin
        k <= k + AW'(1);
      end
      // Capture includes the product retiring in this same cycle.
      if (state == DRAIN && drained) begin
        out_data <= acc_sum;
      end
    end
  end

endmodule
